// File: rtl/alu_exec_mc.sv
// alu_exec_mc: multi-cycle ALU with a valid/ready request port and a
// valid/ready result port.
//
// state | meaning
// IDLE  | waiting for a request, in_ready = 1
// SHIFT | iterative shift in progress, one bit per cycle
// DONE  | result held on the outputs until out_ready
//
// Build option: define ALU_FAST_SHIFT_EN to compute shifts with a
// single-cycle barrel shifter (SHIFT is then never entered and every
// operation completes with latency 1). Without it, shifts take shamt+1
// cycles. Results are identical in both builds.
module alu_exec_mc #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            operation,
    input  logic [DATA_WIDTH-1:0] src_a,
    input  logic [DATA_WIDTH-1:0] src_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  zero,
    output logic                  op_err
);

    localparam int SHAMT_W = $clog2(DATA_WIDTH);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0100;
    localparam logic [3:0] OP_SRA  = 4'b0101;
    localparam logic [3:0] OP_SLL  = 4'b0110;
    localparam logic [3:0] OP_SRL  = 4'b0111;
    localparam logic [3:0] OP_BEQ  = 4'b1000;
    localparam logic [3:0] OP_BLT  = 4'b1001;
    localparam logic [3:0] OP_BGE  = 4'b1010;
    localparam logic [3:0] OP_BNE  = 4'b1011;
    localparam logic [3:0] OP_SLT  = 4'b1100;
    localparam logic [3:0] OP_PASS = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                state_q;
    logic                  in_ready_q;
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic                  zero_q;
    logic                  op_err_q;
    logic [DATA_WIDTH-1:0] shreg_q;
    logic [SHAMT_W-1:0]    cnt_q;
    logic [3:0]            op_q;

    logic [SHAMT_W-1:0]    shamt;
    logic                  is_shift;
    logic                  go_shift;
    logic [DATA_WIDTH-1:0] alu_res_d;
    logic                  alu_err_d;
    logic [DATA_WIDTH-1:0] shreg_d;

    assign shamt    = src_b[SHAMT_W-1:0];
    assign is_shift = (operation == OP_SRA) || (operation == OP_SLL) || (operation == OP_SRL);

`ifdef ALU_FAST_SHIFT_EN
    assign go_shift = 1'b0;
`else
    // A zero shift amount finishes immediately with src_a as the result.
    assign go_shift = is_shift && (shamt != '0);
`endif

    // Single-cycle result for the operation presented on the inputs.
    always_comb begin
        alu_res_d = '0;
        alu_err_d = 1'b0;
        case (operation)
            OP_AND:  alu_res_d = src_a & src_b;
            OP_OR:   alu_res_d = src_a | src_b;
            OP_ADD:  alu_res_d = src_a + src_b;
            OP_XOR:  alu_res_d = src_a ^ src_b;
            OP_SUB:  alu_res_d = src_a - src_b;
`ifdef ALU_FAST_SHIFT_EN
            OP_SRA:  alu_res_d = $unsigned($signed(src_a) >>> shamt);
            OP_SLL:  alu_res_d = src_a << shamt;
            OP_SRL:  alu_res_d = src_a >> shamt;
`else
            OP_SRA, OP_SLL, OP_SRL: alu_res_d = src_a;
`endif
            OP_BEQ:  alu_res_d = {{(DATA_WIDTH-1){1'b0}}, (src_a == src_b)};
            OP_BLT:  alu_res_d = {{(DATA_WIDTH-1){1'b0}}, ($signed(src_a) <  $signed(src_b))};
            OP_BGE:  alu_res_d = {{(DATA_WIDTH-1){1'b0}}, ($signed(src_a) >= $signed(src_b))};
            OP_BNE:  alu_res_d = {{(DATA_WIDTH-1){1'b0}}, (src_a != src_b)};
            OP_SLT:  alu_res_d = {{(DATA_WIDTH-1){1'b0}}, ($signed(src_a) <  $signed(src_b))};
            OP_PASS: alu_res_d = src_b;
            default: alu_err_d = 1'b1;
        endcase
    end

    // One-bit shift step of the iterative shifter, direction from the captured code.
    always_comb begin
        shreg_d = {shreg_q[DATA_WIDTH-2:0], 1'b0};
        case (op_q)
            OP_SRA:  shreg_d = {shreg_q[DATA_WIDTH-1], shreg_q[DATA_WIDTH-1:1]};
            OP_SRL:  shreg_d = {1'b0, shreg_q[DATA_WIDTH-1:1]};
            default: shreg_d = {shreg_q[DATA_WIDTH-2:0], 1'b0};
        endcase
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            op_err_q    <= 1'b0;
            shreg_q     <= '0;
            cnt_q       <= '0;
            op_q        <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_q       <= operation;
                        in_ready_q <= 1'b0;
                        if (go_shift) begin
                            shreg_q <= src_a;
                            cnt_q   <= shamt;
                            state_q <= ST_SHIFT;
                        end else begin
                            result_q    <= alu_res_d;
                            zero_q      <= (alu_res_d == '0);
                            op_err_q    <= alu_err_d;
                            out_valid_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end
                    end
                end
                ST_SHIFT: begin
                    shreg_q <= shreg_d;
                    cnt_q   <= cnt_q - SHAMT_W'(1);
                    // Last step: the counter reaches zero on this edge.
                    if (cnt_q == SHAMT_W'(1)) begin
                        result_q    <= shreg_d;
                        zero_q      <= (shreg_d == '0);
                        op_err_q    <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign op_err    = op_err_q;

endmodule

// File: tb/tb_alu_exec_mc.sv
// Testbench for alu_exec_mc: directed vectors, randomized operations against
// an arithmetic reference model, backpressure, throughput and reset cases.
module tb_alu_exec_mc;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   operation = 4'd0;
    logic [W-1:0] src_a = '0;
    logic [W-1:0] src_b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         zero;
    logic         op_err;

    int tests = 0;
    int fails = 0;

    alu_exec_mc #(.DATA_WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .operation (operation),
        .src_a     (src_a),
        .src_b     (src_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .op_err    (op_err)
    );

    always #5 clk = ~clk;

    // Reference model: plain arithmetic on integer values.
    function automatic void ref_alu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] r, output logic e);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = a;
        longint unsigned ub = b;
        longint unsigned p  = 1;
        longint          q;
        int              n  = int'(b[4:0]);
        for (int i = 0; i < n; i++) p = p * 2;
        e = 1'b0;
        r = '0;
        case (op)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2:  r = W'((ua + ub) % 64'h1_0000_0000);
            4'd3:  r = a ^ b;
            4'd4:  r = W'((ua + 64'h1_0000_0000 - ub) % 64'h1_0000_0000);
            4'd5: begin
                q = sa / longint'(p);
                if (sa < 0 && q * longint'(p) != sa) q = q - 1;
                r = W'(q);
            end
            4'd6:  r = W'((ua * p) % 64'h1_0000_0000);
            4'd7:  r = W'(ua / p);
            4'd8:  r = (ua == ub) ? 1 : 0;
            4'd9:  r = (sa <  sb) ? 1 : 0;
            4'd10: r = (sa >= sb) ? 1 : 0;
            4'd11: r = (ua != ub) ? 1 : 0;
            4'd12: r = (sa <  sb) ? 1 : 0;
            4'd15: r = b;
            default: e = 1'b1;
        endcase
    endfunction

    function automatic int exp_lat(input logic [3:0] op, input logic [W-1:0] b);
`ifdef ALU_FAST_SHIFT_EN
        return 1;
`else
        if (op == 4'd5 || op == 4'd6 || op == 4'd7) return int'(b[4:0]) + 1;
        return 1;
`endif
    endfunction

    // Issue one request from IDLE and wait (bounded) for out_valid; leaves the DUT in DONE.
    task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic z, output logic e,
                         output int lat, output bit busy_ok, output bit done_ok);
        busy_ok = 1'b1;
        for (int i = 0; i < 100 && !in_ready; i++) begin
            @(posedge clk); #1;
        end
        operation = op; src_a = a; src_b = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        operation = 4'($urandom);
        src_a     = $urandom;
        src_b     = $urandom;
        lat = 1;
        while (!out_valid && lat < 100) begin
            if (in_ready !== 1'b0) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        done_ok = (out_valid === 1'b1);
        r = result; z = zero; e = op_err;
    endtask

    // Complete the output handshake; reports whether the DUT is back in IDLE.
    task automatic release_op(output bit idle_ok);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        idle_ok = (in_ready === 1'b1) && (out_valid === 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        tests++;
        if (result !== '0) begin fails++; $display("FAIL reset_result: got %h expected 00000000", result); end
        tests++;
        if (zero !== 1'b1 || op_err !== 1'b0) begin
            fails++; $display("FAIL reset_flags: got zero=%b op_err=%b expected zero=1 op_err=0", zero, op_err);
        end
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [3:0]   ops  [8] = '{4'd2, 4'd5, 4'd6, 4'd12, 4'd10, 4'd11, 4'd13, 4'd6};
        logic [W-1:0] as   [8] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h1234_5678, 32'hFFFF_FFFF,
                                   32'd5, 32'd3, 32'hDEAD_BEEF, 32'h0000_0001};
        logic [W-1:0] bs   [8] = '{32'h0000_0001, 32'd4, 32'd0, 32'd1, 32'd5, 32'd3, 32'h1, 32'd31};
        logic [W-1:0] rs   [8] = '{32'h8000_0000, 32'hF800_0000, 32'h1234_5678, 32'd1,
                                   32'd1, 32'd0, 32'd0, 32'h8000_0000};
        logic         es   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`ifdef ALU_FAST_SHIFT_EN
        int           lats [8] = '{1, 1, 1, 1, 1, 1, 1, 1};
`else
        int           lats [8] = '{1, 5, 1, 1, 1, 1, 1, 32};
`endif
        logic [W-1:0] r;
        logic         z, e;
        int           lat;
        bit           busy_ok, done_ok, idle_ok;
        for (int i = 0; i < 8; i++) begin
            do_op(ops[i], as[i], bs[i], r, z, e, lat, busy_ok, done_ok);
            tests++;
            if (!done_ok || r !== rs[i] || z !== (rs[i] == '0) || e !== es[i]) begin
                fails++;
                $display("FAIL directed_%0d_result: got %h zero=%b err=%b expected %h zero=%b err=%b",
                         i, r, z, e, rs[i], (rs[i] == '0), es[i]);
            end
            tests++;
            if (lat != lats[i] || !busy_ok) begin
                fails++;
                $display("FAIL directed_%0d_latency: got %0d busy_ok=%b expected %0d busy_ok=1", i, lat, busy_ok, lats[i]);
            end
            release_op(idle_ok);
            tests++;
            if (!idle_ok) begin fails++; $display("FAIL directed_%0d_release: got not-idle expected idle", i); end
        end
    endtask

    task automatic test_random();
        logic [3:0]   op;
        logic [W-1:0] a, b, er, r;
        logic         ee, z, e;
        int           lat;
        bit           busy_ok, done_ok, idle_ok;
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 6)) - 32'd3 : $urandom;
            if ($urandom_range(0, 5) == 0) a = b;
            ref_alu(op, a, b, er, ee);
            do_op(op, a, b, r, z, e, lat, busy_ok, done_ok);
            tests++;
            if (!done_ok || r !== er || z !== (er == '0) || e !== ee) begin
                fails++;
                $display("FAIL random_%0d op=%h a=%h b=%h: got %h zero=%b err=%b expected %h zero=%b err=%b",
                         i, op, a, b, r, z, e, er, (er == '0), ee);
            end
            tests++;
            if (lat != exp_lat(op, b) || !busy_ok) begin
                fails++;
                $display("FAIL random_%0d_latency op=%h: got %0d busy_ok=%b expected %0d", i, op, lat, busy_ok, exp_lat(op, b));
            end
            release_op(idle_ok);
            if (!idle_ok) begin
                tests++; fails++;
                $display("FAIL random_%0d_release: got not-idle expected idle", i);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] a, b, r;
        logic         z, e;
        int           lat;
        bit           busy_ok, done_ok;
        a = $urandom; b = $urandom;
        do_op(4'd3, a, b, r, z, e, lat, busy_ok, done_ok);
        tests++;
        if (!done_ok || r !== (a ^ b)) begin
            fails++; $display("FAIL bp_result: got %h expected %h", r, a ^ b);
        end
        operation = 4'd2; src_a = 32'd100; src_b = 32'd200; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== (a ^ b)) begin
                fails++;
                $display("FAIL bp_hold_%0d: got ov=%b ir=%b res=%h expected ov=1 ir=0 res=%h",
                         i, out_valid, in_ready, result, a ^ b);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== (a ^ b)) begin
            fails++;
            $display("FAIL bp_exit: got ov=%b ir=%b res=%h expected ov=0 ir=1 res=%h", out_valid, in_ready, result, a ^ b);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a, b;
        int           n_ov = 0;
        bit           prev = 1'b0, consec = 1'b0, bad_res = 1'b0;
        a = $urandom; b = $urandom;
        operation = 4'd2; src_a = a; src_b = b; in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) begin
                n_ov++;
                if (prev) consec = 1'b1;
                if (result !== a + b) bad_res = 1'b1;
            end
            prev = (out_valid === 1'b1);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        tests++;
        if (n_ov != 10 || consec) begin
            fails++; $display("FAIL b2b_throughput: got %0d results consec=%b expected 10 results consec=0", n_ov, consec);
        end
        tests++;
        if (bad_res) begin fails++; $display("FAIL b2b_result: got wrong sum expected %h", a + b); end
    endtask

    task automatic test_reset_mid_shift();
        logic [W-1:0] r;
        logic         z, e;
        int           lat, n_ov;
        bit           busy_ok, done_ok, idle_ok;
        do_op(4'd2, 32'd1, 32'd1, r, z, e, lat, busy_ok, done_ok);
        release_op(idle_ok);
        operation = 4'd7; src_a = 32'hF000_0000; src_b = 32'd20; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || result !== '0 || zero !== 1'b1 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid_shift: got ov=%b res=%h zero=%b ir=%b expected ov=0 res=0 zero=1 ir=1",
                     out_valid, result, zero, in_ready);
        end
        operation = 4'd2; src_a = 32'd2; src_b = 32'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || result !== 32'd5 || zero !== 1'b0) begin
            fails++;
            $display("FAIL rst_first_accept: got ov=%b res=%h expected ov=1 res=00000005", out_valid, result);
        end
        release_op(idle_ok);
        n_ov = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) n_ov++;
        end
        tests++;
        if (n_ov != 0) begin fails++; $display("FAIL rst_discard: got %0d stray results expected 0", n_ov); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_shift();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_exec_mc.md
ALU_EXEC_MC -- requirements
Module: alu_exec_mc

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning operand/result width; SHAMT_W = log2(DATA_WIDTH).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operation request valid.
REQ-005 SHALL have port in_ready  output  1  block can accept a request.
REQ-006 SHALL have port operation  input  4  ALU operation code per REQ-011.
REQ-007 SHALL have port src_a / src_b  input  DATA_WIDTH each  operands; shift amount = src_b[SHAMT_W-1:0].
REQ-008 SHALL have port out_valid  input-side handshake pair: out_valid output 1 and out_ready input 1, meaning result valid / consumer accepts.
REQ-009 SHALL have port result  output  DATA_WIDTH  registered result.
REQ-010 SHALL have ports zero  output  1  (result == 0), and op_err  output  1  (undefined operation code accepted).

Function
REQ-011 Operation codes: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SUB, 0101 SRA, 0110 SLL, 0111 SRL, 1000 BEQ, 1001 BLT, 1010 BGE, 1011 BNE, 1100 SLT, 1111 PASS_B; 1101/1110 undefined.
REQ-012 Arithmetic modulo 2^DATA_WIDTH, carries discarded; BLT/BGE/SLT compare signed two's complement.
REQ-013 Branch ops and SLT: result = zero-extended 1-bit condition; PASS_B: result = src_b.
REQ-014 Undefined codes: result = 0, op_err = 1, latency as non-shift op; op_err = 0 for all defined codes.
REQ-015 FSM states IDLE, SHIFT, DONE; in_ready = 1 only in IDLE.
REQ-016 Accept occurs when in_valid && in_ready; operands and code captured that edge; inputs ignored otherwise.
REQ-017 Non-shift op: IDLE -> DONE on accept; out_valid high the cycle after accept (latency 1).
REQ-018 Shift op (SLL/SRL/SRA) with shamt n: on accept, load src_a into shift register and n into counter; n == 0 -> DONE directly (latency 1).
REQ-019 In SHIFT: shift one bit per cycle (SRA replicates sign bit), decrement counter; counter reaching 0 -> DONE; out_valid high n+1 cycles after accept.
REQ-020 DONE: out_valid = 1; result, zero, op_err stable until out_valid && out_ready; on that edge -> IDLE.
REQ-021 No same-cycle accept on output handshake; next accept earliest the cycle after DONE exit (max throughput one op per 2 cycles).
REQ-022 out_ready deasserted in IDLE/SHIFT has no effect; out_valid never high outside DONE.

Reset
REQ-023 rst_n low SHALL immediately force state IDLE, out_valid 0, result 0, zero 1, op_err 0, shift counter 0, independent of clk.
REQ-024 Reset mid-SHIFT or in DONE discards the operation; no result is produced for it.
REQ-025 in_ready SHALL be 1 during and after reset; first accept possible on the first rising edge with rst_n high.

Configuration
REQ-026 Macro ALU_FAST_SHIFT_EN defined: shifts computed by single-cycle barrel shifter, SHIFT state unused, all ops latency 1.
REQ-027 Macro ALU_FAST_SHIFT_EN undefined: iterative shifting per REQ-018/019; results identical in both builds, only latency differs.

Verification
REQ-028 ADD 0x7FFFFFFF + 0x00000001 -> result 0x80000000, zero 0, out_valid 1 cycle after accept.
REQ-029 SRA src_a 0x80000000, src_b 4 -> result 0xF8000000 after 5 cycles; in_ready 0 throughout; SLL by 0 -> src_a, latency 1.
REQ-030 SLT -1 vs 1 -> 1; BGE 5,5 -> 1; BNE 3,3 -> 0 with zero 1; code 1101 -> result 0, op_err 1.
REQ-031 out_ready held 0 for 3 cycles in DONE with in_valid 1 -> result stable, in_ready 0, no new accept; out_ready 1 -> IDLE next cycle.
REQ-032 rst_n pulsed low during SRL by 20 -> out_valid 0, result 0 immediately; after release, new ADD 2+3 -> 5 with latency 1.
REQ-033 SLL 0x00000001 by 31 -> 0x80000000, latency 1 with ALU_FAST_SHIFT_EN, 32 without.
